// File: rtl/rr_arb_mux4.sv
// rr_arb_mux4
//   Four-channel round-robin arbiter with a registered output stage. Each
//   channel presents data with a valid bit. The arbiter grants one channel per
//   accepted beat, copies its data into a single-entry output register and
//   rotates priority so that the channel after the winner is searched first
//   next time.
//
// Ports
//   clk        single clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   in0..in3   source channel data, DATA_W bits each
//   in_valid   bit k set when channel k offers a beat
//   in_ready   bit k set when channel k's beat is taken this cycle (one-hot or zero)
//   out        registered data of the granted channel
//   sel        registered index of the channel whose beat is held in out
//   out_valid  out/sel hold a beat
//   out_ready  downstream accepts the held beat this cycle

module rr_arb_mux4 #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [DATA_W-1:0] in3,
    input  logic [3:0]        in_valid,
    output logic [3:0]        in_ready,
    output logic [DATA_W-1:0] out,
    output logic [1:0]        sel,
    output logic              out_valid,
    input  logic              out_ready
);

    logic [1:0]        prio;
    logic [1:0]        grant;
    logic              load;
    logic              accept;
    logic [DATA_W-1:0] grant_data;

    // The output register can take a new beat when it is empty or when its
    // current beat leaves this same cycle, which gives one beat per cycle.
    assign load = ~out_valid | out_ready;

    // Search channels starting at the priority pointer and wrapping modulo 4;
    // the first valid channel wins. With no valid channel the grant value is
    // unused because in_ready stays zero.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        grant = prio;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = prio + 2'(i);
            if (!found && in_valid[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

    // Handshake back to the sources. Reset is folded in explicitly because
    // out_valid is already low in reset, which would otherwise leave load high.
    always_comb begin
        in_ready = 4'b0000;
        if (rst_n && load && (|in_valid)) begin
            in_ready[grant] = 1'b1;
        end
    end

    assign accept = |(in_ready & in_valid);

    // Data multiplexer for the granted channel.
    always_comb begin
        case (grant)
            2'd0:    grant_data = in0;
            2'd1:    grant_data = in1;
            2'd2:    grant_data = in2;
            default: grant_data = in3;
        endcase
    end

    // Output register and priority pointer. An accepted beat always overwrites
    // the register (covering the drain-and-refill case without a bubble); a
    // lone output transfer just empties it, leaving out/sel at their last
    // values. Priority moves only when a source beat is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            sel       <= 2'b00;
            out_valid <= 1'b0;
            prio      <= 2'b00;
        end else if (accept) begin
            out       <= grant_data;
            sel       <= grant;
            out_valid <= 1'b1;
            prio      <= grant + 2'd1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_arb_mux4.sv
// tb_rr_arb_mux4
//   Directed bench for rr_arb_mux4. The stimulus thread drives vectors and
//   pushes the hand-computed beat it expects into a queue. An independent
//   monitor pops that queue whenever the DUT completes an output transfer.
//   Reset, handshake and hold behaviour are checked directly by the stimulus
//   thread.

module tb_rr_arb_mux4;

    localparam int DATA_W = 32;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] in0, in1, in2, in3;
    logic [3:0]        in_valid;
    logic [3:0]        in_ready;
    logic [DATA_W-1:0] out;
    logic [1:0]        sel;
    logic              out_valid;
    logic              out_ready;

    int compared   = 0;
    int mismatched = 0;

    // Expected beats as {sel, data}.
    logic [DATA_W+1:0] exp_q[$];

    rr_arb_mux4 #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [DATA_W-1:0] actual,
                               input logic [DATA_W-1:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic ordy);
        in_valid  = valid;
        out_ready = ordy;
    endtask

    task automatic pushBeat(input logic [1:0] ch);
        logic [DATA_W-1:0] d;
        d = DATA_W'(1) << ch;
        exp_q.push_back({ch, d});
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every output transfer must match the oldest expected beat.
    always @(negedge clk) begin
        logic [DATA_W+1:0] e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_beat: got sel %0d data %0h, expected no beat", sel, out);
            end else begin
                e = exp_q.pop_front();
                checkOutput("beat_data", out, e[DATA_W-1:0]);
                checkOutput("beat_sel", DATA_W'(sel), DATA_W'(e[DATA_W+1:DATA_W]));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        in0 = 32'h1; in1 = 32'h2; in2 = 32'h4; in3 = 32'h8;
        applyStimulus(4'b1111, 1'b1);

        // Reset state with every channel requesting.
        #12;
        checkOutput("reset_out_valid", DATA_W'(out_valid), 0);
        checkOutput("reset_out", out, 0);
        checkOutput("reset_sel", DATA_W'(sel), 0);
        checkOutput("reset_in_ready", DATA_W'(in_ready), 0);

        // Single source on channel 1, then drain.
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'b0010, 1'b1);
        #1;
        checkOutput("single_in_ready", DATA_W'(in_ready), 32'b0010);
        pushBeat(2'd1);
        nextCycle();
        checkOutput("single_out_valid", DATA_W'(out_valid), 1);
        applyStimulus(4'b0000, 1'b1);
        nextCycle();
        checkOutput("drain_out_valid", DATA_W'(out_valid), 0);
        checkOutput("drain_out_hold", out, 32'h2);
        checkOutput("drain_sel_hold", DATA_W'(sel), 1);

        // Wrap/skip: prio is 2; ch2 first, then 0101 alternates 0,2,0.
        applyStimulus(4'b0100, 1'b1);
        #1;
        checkOutput("wrap_in_ready_c1", DATA_W'(in_ready), 32'b0100);
        pushBeat(2'd2);
        nextCycle();
        applyStimulus(4'b0101, 1'b1);
        #1;
        checkOutput("wrap_in_ready_c2", DATA_W'(in_ready), 32'b0001);
        pushBeat(2'd0);
        nextCycle();
        checkOutput("wrap_in_ready_c3", DATA_W'(in_ready), 32'b0100);
        pushBeat(2'd2);
        nextCycle();
        checkOutput("wrap_in_ready_c4", DATA_W'(in_ready), 32'b0001);
        pushBeat(2'd0);
        nextCycle();
        applyStimulus(4'b0000, 1'b1);
        nextCycle();
        checkOutput("wrap_drain_valid", DATA_W'(out_valid), 0);
        checkOutput("wrap_drain_out", out, 32'h1);

        // Mid-operation asynchronous reset while a beat is held. prio is 1.
        applyStimulus(4'b0010, 1'b0);
        #1;
        checkOutput("hold_in_ready_load", DATA_W'(in_ready), 32'b0010);
        nextCycle();
        checkOutput("hold_out_valid", DATA_W'(out_valid), 1);
        checkOutput("hold_out", out, 32'h2);
        checkOutput("hold_in_ready_blocked", DATA_W'(in_ready), 0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_out_valid", DATA_W'(out_valid), 0);
        checkOutput("async_rst_out", out, 0);
        checkOutput("async_rst_sel", DATA_W'(sel), 0);
        checkOutput("async_rst_in_ready", DATA_W'(in_ready), 0);

        // Round robin from reset with three cycles of backpressure after beat one.
        applyStimulus(4'b1111, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rr_in_ready_0", DATA_W'(in_ready), 32'b0001);
        pushBeat(2'd0);
        nextCycle();
        applyStimulus(4'b1111, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("bp_in_ready", DATA_W'(in_ready), 0);
            checkOutput("bp_out_hold", out, 32'h1);
            checkOutput("bp_sel_hold", DATA_W'(sel), 0);
            checkOutput("bp_out_valid", DATA_W'(out_valid), 1);
            nextCycle();
        end
        applyStimulus(4'b1111, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            logic [3:0] exp_rdy;
            exp_rdy = 4'b0001 << (i % 4);
            #1;
            checkOutput("rr_no_bubble", DATA_W'(out_valid), 1);
            checkOutput("rr_in_ready", DATA_W'(in_ready), DATA_W'(exp_rdy));
            pushBeat(2'(i % 4));
            nextCycle();
        end
        applyStimulus(4'b0000, 1'b1);
        nextCycle();
        checkOutput("rr_final_drain", DATA_W'(out_valid), 0);
        nextCycle();
        checkOutput("queue_empty", DATA_W'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/rr_arb_mux4.md
RR_ARB_MUX4 -- requirements
Module: rr_arb_mux4

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of every data channel.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports in0, in1, in2, in3  input  DATA_W each  source channel data.
REQ-005 SHALL have port in_valid  input  4  bit k = channel k has data.
REQ-006 SHALL have port in_ready  output  4  bit k = channel k accepted this cycle.
REQ-007 SHALL have port out  output  DATA_W  registered selected data.
REQ-008 SHALL have port sel  output  2  registered index of channel held in out.
REQ-009 SHALL have port out_valid  output  1  out/sel hold a beat.
REQ-010 SHALL have port out_ready  input  1  downstream accepts beat.

Function
REQ-011 SHALL treat a transfer on channel k as in_valid[k] & in_ready[k] at a rising edge; output transfer as out_valid & out_ready.
REQ-012 SHALL compute load = ~out_valid | out_ready (output register empty or draining this cycle).
REQ-013 SHALL hold a 2-bit priority pointer prio; search order prio, prio+1, prio+2, prio+3 (mod 4); grant = first k in that order with in_valid[k].
REQ-014 SHALL drive in_ready[k] = load & (grant == k) & |in_valid, combinationally; at most one in_ready bit high; in_ready = 4'b0000 when no valid or load low.
REQ-015 SHALL, on a channel-k transfer, register out <= in_k, sel <= k, out_valid <= 1, prio <= k+1 mod 4 (3 wraps to 0), next edge; latency input to out_valid = 1 cycle.
REQ-016 SHALL, on an output transfer with no simultaneous input transfer, clear out_valid next edge; out and sel hold last values.
REQ-017 SHALL, on simultaneous output and input transfer, replace the beat with no bubble (out_valid stays 1), sustaining one beat per cycle.
REQ-018 SHALL hold out, sel, out_valid and prio stable while out_valid & ~out_ready (backpressure); in_ready all 0.
REQ-019 SHALL leave prio unchanged in cycles without an input transfer.
REQ-020 SHALL not drop, duplicate or reorder beats of any single channel; in_valid changes without a transfer SHALL have no effect on state.
REQ-021 SHALL guarantee starvation freedom: a continuously valid channel is granted within 4 input transfers.

Reset
REQ-022 SHALL, while rst_n = 0 (asynchronously, regardless of clk), force out = 0, sel = 2'b00, out_valid = 0, prio = 2'b00.
REQ-023 SHALL drive in_ready = 4'b0000 while rst_n = 0.
REQ-024 SHALL, on reset assertion mid-operation, discard any held beat; first grant after release follows prio = 0 order.
REQ-025 SHALL begin accepting on the first rising edge after rst_n deasserts.

Verification
REQ-026 Reset: rst_n low asynchronously between edges with out_valid = 1 -> out_valid, out, sel read 0 immediately, in_ready = 0000.
REQ-027 Single source: in1 = 32'h00000002, in_valid = 0010, out_ready = 1 -> in_ready = 0010; next cycle out = 00000002, sel = 01, out_valid = 1; prio = 2.
REQ-028 Round robin: in0..in3 = 1,2,4,8, in_valid = 1111 held, out_ready = 1 from reset -> out sequence 1,2,4,8,1,... on consecutive cycles, sel 00,01,10,11,00, no bubbles.
REQ-029 Backpressure: as REQ-028 but out_ready = 0 for 3 cycles after first beat -> out = 1, sel = 00 held, in_ready = 0000 for 3 cycles; on release, next beat out = 2, sel = 01.
REQ-030 Wrap/skip: prio = 3 after grant to ch2, in_valid = 0101 -> grant ch0 (search 3,0), out = in0, prio becomes 1; next grant ch2.
REQ-031 Drain: single beat accepted, then in_valid = 0000, out_ready = 1 -> out_valid falls next cycle, out/sel retain last values.
